// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencer.
// - W_DEF      : default datapath width (two's complement).
// - OP_*       : request opcodes; 001..101 double as ALU control codes.
// - state_e    : sequencer state encoding.
package calc_pkg;

    localparam int unsigned W_DEF = 12;

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_PASS  = 3'b101;
    localparam logic [2:0] OP_LOAD  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/calc_flags.sv
// calc_flags: combinational result flags for the sequencer.
// Ports:
//   a_sign_i  sign of the accumulator operand
//   b_sign_i  sign of the request operand
//   result_i  new accumulator value
//   op_i      opcode being executed
//   zero_o    result == 0
//   neg_o     result sign bit
//   ovf_o     signed overflow, ADD/SUB only
module calc_flags
    import calc_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         a_sign_i,
    input  logic         b_sign_i,
    input  logic [W-1:0] result_i,
    input  logic [2:0]   op_i,
    output logic         zero_o,
    output logic         neg_o,
    output logic         ovf_o
);

    logic r_sign;

    assign r_sign = result_i[W-1];
    assign zero_o = (result_i == '0);
    assign neg_o  = r_sign;

    always_comb begin
        ovf_o = 1'b0;
        unique case (op_i)
            OP_ADD:  ovf_o = (a_sign_i == b_sign_i) && (r_sign != a_sign_i);
            OP_SUB:  ovf_o = (a_sign_i != b_sign_i) && (r_sign != a_sign_i);
            default: ovf_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/calc_seq.sv
// calc_seq: accumulator sequencer in front of a combinational ALU.
// Takes one request at a time (REQ_*), runs it for exactly one EXEC cycle through the
// external ALU (or bypasses it for CLEAR/LOAD), stores the result in ACC and returns it
// with zero/neg/overflow flags on the response handshake (RSP_*).
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   REQ_VALID/READY/OP/OPND   request handshake, opcode and operand
//   RSP_VALID/READY           response handshake
//   RSP_RESULT/ZERO/NEG/OVF   registered response data and flags
//   ERR                       sticky overflow, cleared by CLEAR or reset
//   ACC                       current accumulator
//   ALU_A/ALU_B/ALU_CTRL      drive the external ALU
//   ALU_RESULT                external ALU result
module calc_seq
    import calc_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [2:0]   REQ_OP,
    input  logic [W-1:0] REQ_OPND,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic [W-1:0] RSP_RESULT,
    output logic         RSP_ZERO,
    output logic         RSP_NEG,
    output logic         RSP_OVF,
    output logic         ERR,
    output logic [W-1:0] ACC,
    output logic [W-1:0] ALU_A,
    output logic [W-1:0] ALU_B,
    output logic [2:0]   ALU_CTRL,
    input  logic [W-1:0] ALU_RESULT
);

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           err_q, err_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           neg_q, neg_d;
    logic           ovf_q, ovf_d;

    logic           uses_alu;
    logic [W-1:0]   exec_result;
    logic           f_zero, f_neg, f_ovf;

    // Reserved opcode rides through the ALU as PASS.
    assign uses_alu = (op_q >= OP_ADD) && (op_q <= OP_PASS);

    always_comb begin
        unique case (op_q)
            OP_CLEAR: exec_result = '0;
            OP_LOAD:  exec_result = opnd_q;
            default:  exec_result = ALU_RESULT;
        endcase
    end

    calc_flags #(
        .W (W)
    ) u_flags (
        .a_sign_i (acc_q[W-1]),
        .b_sign_i (opnd_q[W-1]),
        .result_i (exec_result),
        .op_i     (op_q),
        .zero_o   (f_zero),
        .neg_o    (f_neg),
        .ovf_o    (f_ovf)
    );

    // ALU sees ACC as a PASS operation whenever it is not doing real work.
    always_comb begin
        ALU_A    = acc_q;
        ALU_B    = '0;
        ALU_CTRL = OP_PASS;
        if (state_q == StExec && uses_alu) begin
            ALU_B    = opnd_q;
            ALU_CTRL = op_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        err_d    = err_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (REQ_VALID) begin
                    op_d    = REQ_OP;
                    opnd_d  = REQ_OPND;
                    state_d = StExec;
                end
            end
            StExec: begin
                acc_d    = exec_result;
                result_d = exec_result;
                zero_d   = f_zero;
                neg_d    = f_neg;
                ovf_d    = f_ovf;
                err_d    = (op_q == OP_CLEAR) ? 1'b0 : (err_q | f_ovf);
                state_d  = StResp;
            end
            StResp: begin
                if (RSP_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            op_q     <= OP_CLEAR;
            opnd_q   <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign REQ_READY  = (state_q == StIdle);
    assign RSP_VALID  = (state_q == StResp);
    assign RSP_RESULT = result_q;
    assign RSP_ZERO   = zero_q;
    assign RSP_NEG    = neg_q;
    assign RSP_OVF    = ovf_q;
    assign ERR        = err_q;
    assign ACC        = acc_q;

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a behavioural model of the 12-bit ALU.
module tb_calc_seq;

    localparam int W = 12;

    logic         CLK = 1'b0;
    logic         RST;
    logic         REQ_VALID;
    logic         REQ_READY;
    logic [2:0]   REQ_OP;
    logic [W-1:0] REQ_OPND;
    logic         RSP_VALID;
    logic         RSP_READY;
    logic [W-1:0] RSP_RESULT;
    logic         RSP_ZERO;
    logic         RSP_NEG;
    logic         RSP_OVF;
    logic         ERR;
    logic [W-1:0] ACC;
    logic [W-1:0] ALU_A;
    logic [W-1:0] ALU_B;
    logic [2:0]   ALU_CTRL;
    logic [W-1:0] ALU_RESULT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    calc_seq #(
        .W (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_OP     (REQ_OP),
        .REQ_OPND   (REQ_OPND),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_RESULT (RSP_RESULT),
        .RSP_ZERO   (RSP_ZERO),
        .RSP_NEG    (RSP_NEG),
        .RSP_OVF    (RSP_OVF),
        .ERR        (ERR),
        .ACC        (ACC),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_CTRL   (ALU_CTRL),
        .ALU_RESULT (ALU_RESULT)
    );

    // External ALU model
    always_comb begin
        ALU_RESULT = ALU_A;
        case (ALU_CTRL)
            3'b001:  ALU_RESULT = ALU_A + ALU_B;
            3'b010:  ALU_RESULT = ALU_A - ALU_B;
            3'b011:  ALU_RESULT = ALU_A & ALU_B;
            3'b100:  ALU_RESULT = ALU_A | ALU_B;
            default: ALU_RESULT = ALU_A;
        endcase
    end

    // Offer one request, then wait (bounded) for RSP_VALID with RSP_READY low.
    // lat counts clock edges from the accepting edge up to the one raising RSP_VALID.
    task automatic send_op(input logic [2:0] op, input logic [W-1:0] opnd, output int lat,
                           output logic [2:0] ex_ctrl, output logic [W-1:0] ex_a,
                           output logic [W-1:0] ex_b);
        RSP_READY = 1'b0;
        REQ_OP    = op;
        REQ_OPND  = opnd;
        REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        lat     = 1;
        ex_ctrl = ALU_CTRL;
        ex_a    = ALU_A;
        ex_b    = ALU_B;
        while (!RSP_VALID && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic consume();
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 3'b000; REQ_OPND = '0; RSP_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++;
        if ({REQ_READY, RSP_VALID, ERR, RSP_ZERO, RSP_NEG, RSP_OVF} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctl: got rdy,vld,err,z,n,o=%b want 100000",
                     {REQ_READY, RSP_VALID, ERR, RSP_ZERO, RSP_NEG, RSP_OVF});
        end
        n_tests++;
        if (ACC !== 12'h000 || RSP_RESULT !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_data: got acc=%h res=%h want 000/000", ACC, RSP_RESULT);
        end
        n_tests++;
        if (ALU_CTRL !== 3'b101 || ALU_A !== 12'h000 || ALU_B !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_alu: got ctrl=%b a=%h b=%h want 101/000/000",
                     ALU_CTRL, ALU_A, ALU_B);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_load();
        int lat; logic [2:0] c; logic [W-1:0] a, b;
        send_op(3'b110, 12'h005, lat, c, a, b);
        n_tests++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL load_latency: got %0d edges want 2", lat);
        end
        n_tests++;
        if (RSP_RESULT !== 12'h005 || ACC !== 12'h005) begin
            n_fail++; $display("FAIL load_result: got res=%h acc=%h want 005", RSP_RESULT, ACC);
        end
        n_tests++;
        if ({RSP_ZERO, RSP_NEG, RSP_OVF, REQ_READY} !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_flags: got z,n,o,rdy=%b want 0000",
                     {RSP_ZERO, RSP_NEG, RSP_OVF, REQ_READY});
        end
        consume();
    endtask

    task automatic test_sub();
        int lat; logic [2:0] c; logic [W-1:0] a, b;
        send_op(3'b010, 12'h007, lat, c, a, b);
        n_tests++;
        if (c !== 3'b010 || a !== 12'h005 || b !== 12'h007) begin
            n_fail++;
            $display("FAIL sub_exec_alu: got ctrl=%b a=%h b=%h want 010/005/007", c, a, b);
        end
        n_tests++;
        if (RSP_RESULT !== 12'hFFE || {RSP_ZERO, RSP_NEG, RSP_OVF} !== 3'b010) begin
            n_fail++;
            $display("FAIL sub_result: got %h z,n,o=%b want FFE 010",
                     RSP_RESULT, {RSP_ZERO, RSP_NEG, RSP_OVF});
        end
        consume();
    endtask

    task automatic test_overflow();
        int lat; logic [2:0] c; logic [W-1:0] a, b;
        send_op(3'b110, 12'h7FF, lat, c, a, b); consume();
        send_op(3'b001, 12'h001, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h800 || {RSP_NEG, RSP_OVF, ERR} !== 3'b111) begin
            n_fail++;
            $display("FAIL add_ovf: got %h n,o,err=%b want 800 111",
                     RSP_RESULT, {RSP_NEG, RSP_OVF, ERR});
        end
        consume();
        send_op(3'b001, 12'h001, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h801 || {RSP_OVF, ERR} !== 2'b01) begin
            n_fail++;
            $display("FAIL err_sticky: got %h o,err=%b want 801 01", RSP_RESULT, {RSP_OVF, ERR});
        end
        consume();
        send_op(3'b000, 12'h123, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h000 || {RSP_ZERO, RSP_OVF, ERR} !== 3'b100 || ACC !== 12'h000) begin
            n_fail++;
            $display("FAIL clear: got %h acc=%h z,o,err=%b want 000 000 100",
                     RSP_RESULT, ACC, {RSP_ZERO, RSP_OVF, ERR});
        end
        consume();
        send_op(3'b110, 12'h800, lat, c, a, b); consume();
        send_op(3'b010, 12'h001, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h7FF || {RSP_NEG, RSP_OVF, ERR} !== 3'b011) begin
            n_fail++;
            $display("FAIL sub_ovf: got %h n,o,err=%b want 7FF 011",
                     RSP_RESULT, {RSP_NEG, RSP_OVF, ERR});
        end
        consume();
        send_op(3'b000, 12'h000, lat, c, a, b); consume();
    endtask

    task automatic test_logic();
        int lat; logic [2:0] c; logic [W-1:0] a, b;
        send_op(3'b110, 12'hF0F, lat, c, a, b); consume();
        send_op(3'b011, 12'h0FF, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h00F || c !== 3'b011) begin
            n_fail++; $display("FAIL and: got %h ctrl=%b want 00F 011", RSP_RESULT, c);
        end
        consume();
        send_op(3'b100, 12'h300, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h30F) begin
            n_fail++; $display("FAIL or: got %h want 30F", RSP_RESULT);
        end
        consume();
        send_op(3'b111, 12'hABC, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h30F || ACC !== 12'h30F || RSP_OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved: got %h acc=%h o=%b want 30F 30F 0", RSP_RESULT, ACC, RSP_OVF);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat; logic [2:0] c; logic [W-1:0] a, b;
        send_op(3'b110, 12'h123, lat, c, a, b);
        REQ_OP = 3'b110; REQ_OPND = 12'h456; REQ_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            n_tests++;
            if ({RSP_VALID, REQ_READY} !== 2'b10 || RSP_RESULT !== 12'h123 || ACC !== 12'h123) begin
                n_fail++;
                $display("FAIL hold_%0d: got vld,rdy=%b res=%h acc=%h want 10 123 123",
                         i, {RSP_VALID, REQ_READY}, RSP_RESULT, ACC);
            end
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        n_tests++;
        if ({RSP_VALID, REQ_READY} !== 2'b01 || ACC !== 12'h123) begin
            n_fail++;
            $display("FAIL release: got vld,rdy=%b acc=%h want 01 123", {RSP_VALID, REQ_READY}, ACC);
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        n_tests++;
        if (REQ_READY !== 1'b0) begin
            n_fail++; $display("FAIL next_accept: got rdy=%b want 0", REQ_READY);
        end
        @(posedge CLK); #1;
        n_tests++;
        if (RSP_VALID !== 1'b1 || RSP_RESULT !== 12'h456) begin
            n_fail++;
            $display("FAIL next_result: got vld=%b res=%h want 1 456", RSP_VALID, RSP_RESULT);
        end
        consume();
    endtask

    task automatic test_reset_mid_exec();
        int lat; logic [2:0] c; logic [W-1:0] a, b;
        send_op(3'b110, 12'h7FF, lat, c, a, b); consume();
        send_op(3'b001, 12'h001, lat, c, a, b); consume();
        REQ_OP = 3'b001; REQ_OPND = 12'h010; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        n_tests++;
        if ({RSP_VALID, ERR, REQ_READY} !== 3'b001 || ACC !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_exec: got vld,err,rdy=%b acc=%h want 001 000",
                     {RSP_VALID, ERR, REQ_READY}, ACC);
        end
        @(posedge CLK); #1;
        n_tests++;
        if ({RSP_VALID, REQ_READY} !== 2'b01 || ACC !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_dropped: got vld,rdy=%b acc=%h want 01 000",
                     {RSP_VALID, REQ_READY}, ACC);
        end
        send_op(3'b001, 12'h003, lat, c, a, b);
        n_tests++;
        if (RSP_RESULT !== 12'h003 || lat !== 2) begin
            n_fail++;
            $display("FAIL rst_recover: got %h lat=%0d want 003 2", RSP_RESULT, lat);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_load();
        test_sub();
        test_overflow();
        test_logic();
        test_back_to_back();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
